microcode_sequencer: RTL

- Sequences `microcode_exec`: owns the micro-program counter (uPC), reads one 32-bit microword per step from the microcode store, and hands the control field to the executor.
- Resolves next-address ops: sequential, jump, conditional branch, call/return on a small hardware stack, opcode dispatch, halt.
- Sits between the microcode store (`uops` array / ROM) and the executor.
- Flags sequencing errors and does not execute past them.

---
 rtl/ucode_pkg.sv | 33 +++
 rtl/ucode_call_stack.sv | 49 ++++
 rtl/microcode_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/ucode_pkg.sv
// rtl/ucode_pkg.sv - microword layout, sequencing ops and sequencer states
package ucode_pkg;

   localparam int SEQ_MSB      = 31;
   localparam int SEQ_LSB      = 28;
   localparam int TGT_MSB      = 27;
   localparam int TGT_LSB      = 20;
   localparam int UCODE_CTRL_W = 20;

   typedef enum logic [3:0] {
      OP_NEXT     = 4'd0,
      OP_JUMP     = 4'd1,
      OP_BRC      = 4'd2,
      OP_CALL     = 4'd3,
      OP_RET      = 4'd4,
      OP_DISPATCH = 4'd5,
      OP_HALT     = 4'd6
   } seq_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2,
      ST_FAULT  = 2'd3
   } state_e;

   // Assembler helper: packs one microword.
   function automatic logic [31:0] mk_uword(seq_op_e op, logic [7:0] tgt,
                                            logic [UCODE_CTRL_W-1:0] ctrl);
      return {op, tgt, ctrl};
   endfunction

endpackage

// File: rtl/ucode_call_stack.sv
// rtl/ucode_call_stack.sv - LIFO of return addresses for CALL/RET
module ucode_call_stack
   import ucode_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top_data,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(STACK_DEPTH);
   localparam logic [PTR_W:0] ONE     = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(STACK_DEPTH);

   logic [PTR_W:0]    sp;
   logic [PTR_W:0]    sp_dec;
   logic [ADDR_W-1:0] mem [STACK_DEPTH];

   assign full   = (sp == DEPTH_V);
   assign empty  = (sp == '0);
   assign sp_dec = sp - ONE;
   assign top_data = mem[sp_dec[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + ONE;
      end else if (pop && !empty) begin
         sp <= sp_dec;
      end
   end

   // Storage is intentionally not reset; only entries below sp are ever read.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[sp[PTR_W-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - micro-PC sequencer between microcode store and executor
module microcode_sequencer
   import ucode_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4,
   parameter int CTRL_W      = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   output logic              uop_valid,
   output logic [CTRL_W-1:0] uop_ctrl,
   input  logic              uop_ready,
   input  logic              cond_flag,
   input  logic [ADDR_W-1:0] dispatch_addr,
   output logic [ADDR_W-1:0] upc,
   output logic              busy,
   output logic              halted,
   output logic              fault
);

   state_e            state, state_nx;
   logic [ADDR_W-1:0] upc_q, upc_nx, upc_inc;
   logic [ADDR_W-1:0] target, stk_top;
   seq_op_e           op;
   logic              stk_push, stk_pop, stk_clear, stk_full, stk_empty;

   assign op      = seq_op_e'(rom_data[SEQ_MSB:SEQ_LSB]);
   assign target  = rom_data[TGT_LSB +: ADDR_W];
   assign upc_inc = upc_q + ADDR_W'(1);

   assign rom_addr  = upc_q;
   assign upc       = upc_q;
   assign uop_valid = (state == ST_RUN);
   assign uop_ctrl  = uop_valid ? rom_data[CTRL_W-1:0] : '0;
   assign busy      = (state == ST_RUN);
   assign halted    = (state == ST_HALTED);
   assign fault     = (state == ST_FAULT);

   ucode_call_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk       (clk),
      .reset     (reset),
      .clear     (stk_clear),
      .push      (stk_push),
      .pop       (stk_pop),
      .push_data (upc_inc),
      .top_data  (stk_top),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         upc_q <= '0;
      end else begin
         state <= state_nx;
         upc_q <= upc_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      upc_nx    = upc_q;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_clear = 1'b0;
      unique case (state)
         ST_IDLE, ST_HALTED: begin
            if (start) begin
               upc_nx    = start_addr;
               stk_clear = 1'b1;
               state_nx  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (uop_ready) begin
               case (op)
                  OP_JUMP:     upc_nx = target;
                  OP_BRC:      upc_nx = cond_flag ? target : upc_inc;
                  OP_CALL: begin
                     // Overflow leaves uPC and sp untouched so the faulting word is visible.
                     if (stk_full) begin
                        state_nx = ST_FAULT;
                     end else begin
                        stk_push = 1'b1;
                        upc_nx   = target;
                     end
                  end
                  OP_RET: begin
                     if (stk_empty) begin
                        state_nx = ST_FAULT;
                     end else begin
                        stk_pop = 1'b1;
                        upc_nx  = stk_top;
                     end
                  end
                  OP_DISPATCH: upc_nx = dispatch_addr;
                  OP_HALT:     state_nx = ST_HALTED;
                  default:     upc_nx = upc_inc;
               endcase
            end
         end
         default: ;
      endcase
   end

endmodule
